// File: rtl/eth_crc32_engine.sv
// eth_crc32_engine: IEEE 802.3 CRC-32 FCS generate/check over 1, 2 or 4 bytes per beat
module eth_crc32_engine #(
  parameter int DATA_BYTES = 1,
  parameter int LEN_W = 16
) (
  input  logic                      ieth_clk,
  input  logic                      ieth_rst,
  input  logic                      imode,
  input  logic                      isof,
  input  logic                      ieth_ena,
  input  logic [8*DATA_BYTES-1:0]   ieth_data,
  input  logic [$clog2(DATA_BYTES):0] ibyte_cnt,
  input  logic                      ipayload_end,
  output logic [0:3][7:0]           ocrc32_data,
  output logic                      ocrc_valid,
  output logic                      ocrc_ok,
  output logic                      ocrc_err,
  output logic [LEN_W-1:0]          oframe_len,
  output logic                      obusy
);
  localparam int NW = $clog2(DATA_BYTES) + 1;
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state;
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_nxt;
  logic [LEN_W:0] cnt_sum;
  logic [NW-1:0] n;
  logic mode_q;
  logic mode_eff;
  logic take;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    n = (ipayload_end && ibyte_cnt != '0 && ibyte_cnt <= NW'(DATA_BYTES)) ? ibyte_cnt : NW'(DATA_BYTES);
    crc_nxt = isof ? 32'hFFFFFFFF : crc_q;
    for (int k = 0; k < DATA_BYTES; k++)
      if (k < int'(n)) crc_nxt = crc_byte(crc_nxt, ieth_data[8*k +: 8]);
    cnt_sum = (isof ? '0 : {1'b0, cnt_q}) + (LEN_W+1)'(n);
    cnt_nxt = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
    mode_eff = isof ? imode : mode_q;
    take = ieth_ena && (isof || state == COUNT);
  end
  always_ff @(posedge ieth_clk) begin
    ocrc_valid <= 1'b0;
    if (ieth_rst) begin
      state <= IDLE;
      crc_q <= '1;
      cnt_q <= '0;
      mode_q <= 1'b0;
      ocrc32_data <= '0;
      ocrc_ok <= 1'b0;
      ocrc_err <= 1'b0;
      oframe_len <= '0;
    end else if (take && ipayload_end) begin
      state <= IDLE;
      crc_q <= '1;
      cnt_q <= '0;
      ocrc32_data <= {~crc_nxt[7:0], ~crc_nxt[15:8], ~crc_nxt[23:16], ~crc_nxt[31:24]};
      ocrc_ok <= mode_eff && crc_nxt == 32'hDEBB20E3;
      ocrc_err <= mode_eff && crc_nxt != 32'hDEBB20E3;
      oframe_len <= cnt_nxt;
      ocrc_valid <= 1'b1;
    end else if (take) begin
      state <= COUNT;
      crc_q <= crc_nxt;
      cnt_q <= cnt_nxt;
      mode_q <= mode_eff;
    end
  end
  assign obusy = state == COUNT;
endmodule

// File: tb/tb_eth_crc32_engine.sv
// tb_eth_crc32_engine: randomized frames on 1/2/4-byte engines against a bit-serial CRC model
module tb_eth_crc32_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [31:0] d [3];
  logic [2:0] bc [3];
  logic ena [3];
  logic sof [3];
  logic eop [3];
  logic md [3];
  logic [0:3][7:0] crc [3];
  logic valid [3];
  logic ok [3];
  logic err [3];
  logic busy [3];
  logic [15:0] len0, len1;
  logic [5:0] len2;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  typedef logic [7:0] bq_t[$];
  typedef struct {int u; logic [31:0] fcs; logic [15:0] len; logic ok; logic err; int due;} exp_t;
  exp_t expq[$];

  eth_crc32_engine #(.DATA_BYTES(1), .LEN_W(16)) u0 (.ieth_clk(clk), .ieth_rst(rst), .imode(md[0]),
    .isof(sof[0]), .ieth_ena(ena[0]), .ieth_data(d[0][7:0]), .ibyte_cnt(bc[0][0:0]), .ipayload_end(eop[0]),
    .ocrc32_data(crc[0]), .ocrc_valid(valid[0]), .ocrc_ok(ok[0]), .ocrc_err(err[0]), .oframe_len(len0), .obusy(busy[0]));
  eth_crc32_engine #(.DATA_BYTES(2), .LEN_W(16)) u1 (.ieth_clk(clk), .ieth_rst(rst), .imode(md[1]),
    .isof(sof[1]), .ieth_ena(ena[1]), .ieth_data(d[1][15:0]), .ibyte_cnt(bc[1][1:0]), .ipayload_end(eop[1]),
    .ocrc32_data(crc[1]), .ocrc_valid(valid[1]), .ocrc_ok(ok[1]), .ocrc_err(err[1]), .oframe_len(len1), .obusy(busy[1]));
  eth_crc32_engine #(.DATA_BYTES(4), .LEN_W(6)) u2 (.ieth_clk(clk), .ieth_rst(rst), .imode(md[2]),
    .isof(sof[2]), .ieth_ena(ena[2]), .ieth_data(d[2]), .ibyte_cnt(bc[2]), .ipayload_end(eop[2]),
    .ocrc32_data(crc[2]), .ocrc_valid(valid[2]), .ocrc_ok(ok[2]), .ocrc_err(err[2]), .oframe_len(len2), .obusy(busy[2]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] lenval(input int u);
    return u == 0 ? len0 : u == 1 ? len1 : {10'd0, len2};
  endfunction

  // MSB-first register with LSB-first input bits, bit-reversed at the end
  function automatic logic [31:0] crc_reg(input bq_t fr, input int cnt);
    logic [31:0] c = '1;
    logic [31:0] r;
    for (int i = 0; i < cnt; i++)
      for (int j = 0; j < 8; j++) begin
        logic b = fr[i][j] ^ c[31];
        c = {c[30:0], 1'b0} ^ (b ? 32'h04C11DB7 : 32'h0);
      end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return r;
  endfunction

  function automatic bq_t make_frame(input logic m, input int n, input bit good);
    bq_t f;
    logic [31:0] fcs;
    int p;
    for (int i = 0; i < n; i++) f.push_back(8'($urandom));
    if (m) begin
      fcs = ~crc_reg(f, n);
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
      if (!good) begin
        p = $urandom_range(0, n + 3);
        f[p] = f[p] ^ (8'd1 << $urandom_range(0, 7));
      end
    end
    return f;
  endfunction

  task automatic push_exp(input int u, input logic m, input bq_t fr);
    exp_t e;
    logic [31:0] f;
    int s = fr.size();
    int lmax = (u == 2) ? 63 : 65535;
    f = ~crc_reg(fr, s);
    e.u = u;
    e.fcs = {f[7:0], f[15:8], f[23:16], f[31:24]};
    e.len = 16'(s > lmax ? lmax : s);
    e.ok = m && s >= 4 && (~crc_reg(fr, s - 4) == {fr[s-1], fr[s-2], fr[s-3], fr[s-4]});
    e.err = m && !e.ok;
    e.due = cyc + 1;
    expq.push_back(e);
  endtask

  task automatic send(input int u, input logic m, input bq_t fr, input bit gaps, input bit fin);
    int db = (u == 0) ? 1 : (u == 1) ? 2 : 4;
    int rem;
    for (int i = 0; i < fr.size(); i += db) begin
      bit last = fin && (i + db >= fr.size());
      while (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        ena[u] = 1'b0;
        sof[u] = 1'($urandom_range(0, 1));
        eop[u] = 1'($urandom_range(0, 1));
        d[u] = $urandom;
      end
      @(negedge clk);
      ena[u] = 1'b1;
      sof[u] = (i == 0);
      eop[u] = last;
      md[u] = (i == 0) ? m : 1'($urandom_range(0, 1));
      d[u] = $urandom;
      bc[u] = 3'($urandom);
      for (int k = 0; k < db && i + k < fr.size(); k++) d[u][8*k +: 8] = fr[i+k];
      if (last) begin
        rem = fr.size() - i;
        bc[u] = (rem == db && $urandom_range(0, 1) == 1) ? 3'd0 : 3'(rem);
        push_exp(u, m, fr);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        ena[u] = 1'b0;
        sof[u] = 1'b0;
        eop[u] = 1'b0;
      end
    end
  endtask

  task automatic junk(input int u, input int n);
    repeat (n) begin
      @(negedge clk);
      ena[u] = 1'b1;
      sof[u] = 1'b0;
      eop[u] = 1'($urandom_range(0, 1));
      d[u] = $urandom;
    end
  endtask

  task automatic check_zero(input string tag, input int u);
    check({tag, "_crc"}, crc[u], 0);
    check({tag, "_valid"}, valid[u], 0);
    check({tag, "_ok"}, ok[u], 0);
    check({tag, "_err"}, err[u], 0);
    check({tag, "_len"}, lenval(u), 0);
    check({tag, "_busy"}, busy[u], 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 3; u++)
      if (valid[u]) begin
        if (expq.size() == 0 || expq[0].u != u) check("spurious_valid", valid[u], 0);
        else begin
          e = expq.pop_front();
          check("fcs", crc[u], e.fcs);
          check("frame_len", lenval(u), e.len);
          check("crc_ok", ok[u], e.ok);
          check("crc_err", err[u], e.err);
          check("latency", cyc, e.due);
        end
      end
    if (expq.size() > 0 && expq[0].due < cyc) begin
      e = expq.pop_front();
      check("missing_valid", cyc, e.due);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s, f, g;
    logic m;
    for (int u = 0; u < 3; u++) begin
      d[u] = '0;
      bc[u] = '0;
      ena[u] = 1'b0;
      sof[u] = 1'b0;
      eop[u] = 1'b0;
      md[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) check_zero("reset", u);
    rst = 1'b0;
    s = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send(0, 1'b0, s, 1'b0, 1'b1);
    idle(3);
    check("gen1_fcs", crc[0], 32'h2639F4CB);
    check("gen1_len", len0, 9);
    send(2, 1'b0, s, 1'b1, 1'b1);
    idle(3);
    check("gen4_fcs", crc[2], 32'h2639F4CB);
    f = s;
    f.push_back(8'h26);
    f.push_back(8'h39);
    f.push_back(8'hF4);
    f.push_back(8'hCB);
    send(1, 1'b1, f, 1'b0, 1'b1);
    idle(3);
    check("chk2_ok", ok[1], 1);
    check("chk2_len", len1, 13);
    f[4] = 8'h34;
    send(1, 1'b1, f, 1'b0, 1'b1);
    idle(3);
    check("chk2_bad_err", err[1], 1);
    check("chk2_bad_ok", ok[1], 0);
    for (int u = 0; u < 3; u++) begin
      send(u, 1'b0, make_frame(1'b0, 10, 1'b1), 1'b1, 1'b0);
      @(negedge clk);
      ena[u] = 1'b0;
      check("busy_mid", busy[u], 1);
      m = 1'($urandom_range(0, 1));
      send(u, m, make_frame(m, 12, 1'b1), 1'b1, 1'b1);
      idle(3);
      check("busy_after", busy[u], 0);
    end
    for (int u = 0; u < 3; u++) begin
      send(u, 1'b1, make_frame(1'b1, 12, 1'b1), 1'b0, 1'b0);
      @(negedge clk);
      ena[u] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero("midrst", u);
      send(u, 1'b1, make_frame(1'b1, 7, 1'b1), 1'b0, 1'b1);
      idle(3);
    end
    g = make_frame(1'b0, 3, 1'b1);
    send(2, 1'b0, g, 1'b0, 1'b1);
    repeat (3) begin
      idle(1);
      check("single_busy", busy[2], 0);
    end
    g = make_frame(1'b0, 1, 1'b1);
    send(0, 1'b0, g, 1'b0, 1'b1);
    idle(1);
    check("single_busy0", busy[0], 0);
    idle(2);
    for (int u = 0; u < 3; u++) begin
      send(u, 1'b0, make_frame(1'b0, 9, 1'b1), 1'b0, 1'b1);
      send(u, 1'b1, make_frame(1'b1, 6, 1'b1), 1'b0, 1'b1);
      send(u, 1'b1, make_frame(1'b1, 5, 1'b0), 1'b0, 1'b1);
      idle(3);
    end
    for (int it = 0; it < 40; it++) begin
      int u = $urandom_range(0, 2);
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) junk(u, 2);
      send(u, m, make_frame(m, $urandom_range(1, 90), $urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1, 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(5);
    check("drain", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
